// File: rtl/bundler_ch.sv
// bundler_ch: per-channel bitwise majority bundler over NUM_HVS hypervectors, LFSR-driven tie-break.
// Optional macro BUNDLER_CH_DET_TIE_EN: ties resolve to constant START_VAL (no LFSR).  Rev 1.0
`default_nettype none

module bundler_ch #(
  parameter int                    DIMENSIONS = 5,
  parameter int                    NUM_HVS    = 4,
  parameter int                    NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]   SEED       = 16'b1001010010110101,
  parameter int                    NUM_VALS   = 5,
  parameter logic [NUM_VALS-1:0]   START_VAL  = 5'b10101
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [DIMENSIONS-1:0] hv_array [NUM_HVS-1:0],
  output logic [DIMENSIONS-1:0] hvout
);

  localparam int CNT_W = $clog2(NUM_HVS + 1);
  localparam logic [CNT_W:0] NUM_HVS_W = (CNT_W + 1)'(NUM_HVS);

  if (NUM_HVS < 2) begin : g_bad_num_hvs
    $error("bundler_ch: NUM_HVS must be >= 2");
  end
  if (NUM_VALS < DIMENSIONS) begin : g_bad_num_vals
    $error("bundler_ch: NUM_VALS must be >= DIMENSIONS");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("bundler_ch: SEED must be nonzero to avoid LFSR lockup");
  end

  logic [DIMENSIONS-1:0] tie_bits;
  logic [DIMENSIONS-1:0] maj;

`ifdef BUNDLER_CH_DET_TIE_EN

  assign tie_bits = START_VAL[DIMENSIONS-1:0];

`else

  logic [NUM_REGS-1:0] lfsr;
  logic [NUM_VALS-1:0] tie_reg;
  logic                fb;

  if (NUM_REGS == 16) begin : g_taps16
    assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  end else if (NUM_REGS == 8) begin : g_taps8
    assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  end else if (NUM_REGS == 32) begin : g_taps32
    assign fb = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];
  end else begin : g_bad_num_regs
    $error("bundler_ch: NUM_REGS must be 8, 16 or 32");
  end

  // Both registers free-run every cycle so the tie pattern is independent of input activity.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lfsr    <= SEED;
      tie_reg <= START_VAL;
    end else begin
      lfsr    <= {lfsr[NUM_REGS-2:0], fb};
      tie_reg <= {tie_reg[NUM_VALS-2:0], lfsr[NUM_REGS-1]};
    end
  end

  assign tie_bits = tie_reg[DIMENSIONS-1:0];

`endif

  always_comb begin
    maj = '0;
    for (int d = 0; d < DIMENSIONS; d++) begin
      logic [CNT_W-1:0] cnt;
      logic [CNT_W:0]   twice;
      cnt = '0;
      for (int i = 0; i < NUM_HVS; i++) begin
        cnt = cnt + CNT_W'(hv_array[i][d]);
      end
      twice = {cnt, 1'b0};
      if (twice > NUM_HVS_W) begin
        maj[d] = 1'b1;
      end else if (twice < NUM_HVS_W) begin
        maj[d] = 1'b0;
      end else begin
        maj[d] = tie_bits[d];
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hvout <= '0;
    end else begin
      hvout <= maj;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bundler_ch.sv
// tb_bundler_ch: directed self-checking bench for bundler_ch (default and BUNDLER_CH_DET_TIE_EN builds).
`default_nettype none

module tb_bundler_ch;

  logic       clk;
  logic       nrst;
  logic [4:0] hv [3:0];
  logic [4:0] hvout;

  int checks = 0;
  int errors = 0;

  bundler_ch dut (
    .clk      (clk),
    .nrst     (nrst),
    .hv_array (hv),
    .hvout    (hvout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hv(input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] c, input logic [4:0] d);
    hv[0] = a; hv[1] = b; hv[2] = c; hv[3] = d;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    nrst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    set_hv(5'b11111, 5'b10111, 5'b11101, 5'b11011);
    nrst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (hvout !== 5'b00000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %b expected 00000", k, hvout);
      end
    end
    @(negedge clk);
    nrst = 1'b1;
    set_hv(5'b11111, 5'b11111, 5'b11111, 5'b11111);
    tick();
    checks++;
    if (hvout !== 5'b11111) begin
      errors++;
      $display("FAIL reset_release: got %b expected 11111", hvout);
    end
    #2;
    nrst = 1'b0;
    #1;
    checks++;
    if (hvout !== 5'b00000) begin
      errors++;
      $display("FAIL reset_async: got %b expected 00000", hvout);
    end
  endtask

  task automatic test_first_bundle();
    apply_reset();
    set_hv(5'b01101, 5'b00111, 5'b00011, 5'b00011);
    tick();
    checks++;
    if (hvout !== 5'b00111) begin
      errors++;
      $display("FAIL first_bundle: got %b expected 00111", hvout);
    end
    set_hv(5'b00010, 5'b00001, 5'b01001, 5'b00100);
    tick();
    checks++;
    if (hvout !== 5'b00001) begin
      errors++;
      $display("FAIL second_bundle: got %b expected 00001", hvout);
    end
  endtask

  task automatic test_unanimous();
    set_hv(5'b11111, 5'b11111, 5'b11111, 5'b11111);
    tick();
    checks++;
    if (hvout !== 5'b11111) begin
      errors++;
      $display("FAIL all_ones: got %b expected 11111", hvout);
    end
    set_hv(5'b00000, 5'b00000, 5'b00000, 5'b00000);
    tick();
    checks++;
    if (hvout !== 5'b00000) begin
      errors++;
      $display("FAIL all_zeros: got %b expected 00000", hvout);
    end
    // Bit counts 3,1,4,0,3: no ties, pure majority.
    set_hv(5'b10101, 5'b11101, 5'b10101, 5'b00100);
    tick();
    checks++;
    if (hvout !== 5'b10101) begin
      errors++;
      $display("FAIL mixed_majority: got %b expected 10101", hvout);
    end
  endtask

  task automatic run_tie_seq(input string tag, input int ncyc);
    logic [4:0] exp_tie [20];
`ifdef BUNDLER_CH_DET_TIE_EN
    for (int k = 0; k < 20; k++) exp_tie[k] = 5'b10101;
`else
    exp_tie = '{5'b10101, 5'b01011, 5'b10110, 5'b01100, 5'b11001,
                5'b10010, 5'b00101, 5'b01010, 5'b10100, 5'b01001,
                5'b10010, 5'b00101, 5'b01011, 5'b10110, 5'b01101,
                5'b11010, 5'b10101, 5'b01011, 5'b10111, 5'b01111};
`endif
    set_hv(5'b11111, 5'b11111, 5'b00000, 5'b00000);
    for (int k = 0; k < ncyc; k++) begin
      tick();
      checks++;
      if (hvout !== exp_tie[k]) begin
        errors++;
        $display("FAIL %s cycle %0d: got %b expected %b", tag, k, hvout, exp_tie[k]);
      end
    end
  endtask

  task automatic test_tie_sequence();
    apply_reset();
    run_tie_seq("tie_seq", 20);
  endtask

  task automatic test_mid_reset();
    apply_reset();
    run_tie_seq("tie_pre_reset", 7);
    #2;
    nrst = 1'b0;
    #1;
    checks++;
    if (hvout !== 5'b00000) begin
      errors++;
      $display("FAIL mid_reset_async: got %b expected 00000", hvout);
    end
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    run_tie_seq("tie_restart", 20);
  endtask

  initial begin
    nrst = 1'b0;
    set_hv(5'b00000, 5'b00000, 5'b00000, 5'b00000);
    test_reset();
    test_first_bundle();
    test_unanimous();
    test_tie_sequence();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
